// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative multiply/divide unit with architectural HI/LO, EX stage.
//   clk, reset   : clock, asynchronous active-high reset
//   start, md_op : op valid + code (0 mult,1 multu,2 div,3 divu,4 mthi,5 mtlo,6-7 nop)
//   a, b         : rs / rt operands after forwarding
//   busy         : multi-cycle op in flight (hazard logic stalls on start|busy)
//   hi, lo       : architectural HI / LO
// Optional feature: define EX_MULDIV_DIV_EN to build div/divu; otherwise they are
// no-ops and no divider is built.
module ex_muldiv #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [31:0] hi_n, lo_n;
  logic        latch;
  logic [31:0] a_q, b_q;
  logic        sgn_q;          // signed op (mult/div)
  logic        div_q;          // latched op is a divide
  logic [63:0] result;
  logic        wr_en;

  // Sign/zero extend to 64 bits: the low 64 bits of the product are then
  // correct for both signed and unsigned operands.
  logic [63:0] mul_res;
  assign mul_res = {{32{sgn_q & a_q[31]}}, a_q} * {{32{sgn_q & b_q[31]}}, b_q};

`ifdef EX_MULDIV_DIV_EN
  // Divide on magnitudes, then fix signs: quotient truncates toward zero,
  // remainder follows the dividend. 0x80000000 / -1 falls out as 0x80000000.
  logic        a_neg, b_neg;
  logic [31:0] ua, ub, ub_safe, uq, ur, q, r;
  assign a_neg   = sgn_q & a_q[31];
  assign b_neg   = sgn_q & b_q[31];
  assign ua      = a_neg ? (32'd0 - a_q) : a_q;
  assign ub      = b_neg ? (32'd0 - b_q) : b_q;
  assign ub_safe = (ub == 32'd0) ? 32'd1 : ub;   // result discarded when b==0
  assign uq      = ua / ub_safe;
  assign ur      = ua % ub_safe;
  assign q       = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
  assign r       = a_neg ? (32'd0 - ur) : ur;
  assign result  = div_q ? {r, q} : mul_res;
  assign wr_en   = !(div_q && (b_q == 32'd0));
`else
  logic unused_div_cfg;
  assign unused_div_cfg = (DIV_CYCLES != 0);
  assign result = mul_res;
  assign wr_en  = 1'b1;
`endif

  assign busy = (state == RUN);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hi_n    = hi;
    lo_n    = lo;
    latch   = 1'b0;
    case (state)
      IDLE: if (start) begin
        case (md_op)
          3'd0, 3'd1: begin
            state_n = RUN;
            cnt_n   = 4'(MULT_CYCLES);
            latch   = 1'b1;
          end
`ifdef EX_MULDIV_DIV_EN
          3'd2, 3'd3: begin
            state_n = RUN;
            cnt_n   = 4'(DIV_CYCLES);
            latch   = 1'b1;
          end
`endif
          3'd4:    hi_n = a;
          3'd5:    lo_n = a;
          default: ;
        endcase
      end
      RUN: begin
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_n = IDLE;
          if (wr_en) begin
            hi_n = result[63:32];
            lo_n = result[31:0];
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      hi    <= hi_n;
      lo    <= lo_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      sgn_q <= 1'b0;
      div_q <= 1'b0;
    end else if (latch) begin
      a_q   <= a;
      b_q   <= b;
      sgn_q <= ~md_op[0];
      div_q <= md_op[1];
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed vector table plus hand sequences for ex_muldiv.
module tb_ex_muldiv;

`ifdef EX_MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] a = 32'd0, b = 32'd0;
  logic        busy;
  logic [31:0] hi, lo;

  ex_muldiv #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          cyc;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t v[14];

  initial begin
    logic [31:0] ph, pl, eh, el;
    int ec, n;

    v[0]  = '{3'd0, 32'hFFFFFFFE, 32'd3,        5,  32'hFFFFFFFF, 32'hFFFFFFFA};
    v[1]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001};
    v[2]  = '{3'd0, 32'h80000000, 32'h80000000, 5,  32'h40000000, 32'h00000000};
    v[3]  = '{3'd1, 32'h80000000, 32'd2,        5,  32'h00000001, 32'h00000000};
    v[4]  = '{3'd0, 32'd7,        32'hFFFFFFFD, 5,  32'hFFFFFFFF, 32'hFFFFFFEB};
    v[5]  = '{3'd4, 32'h11111111, 32'd0,        0,  32'h11111111, 32'hFFFFFFEB};
    v[6]  = '{3'd5, 32'h22222222, 32'd0,        0,  32'h11111111, 32'h22222222};
    v[7]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    v[8]  = '{3'd3, 32'd5,        32'd0,        10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    v[9]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
    v[10] = '{3'd3, 32'hFFFFFFFF, 32'd10,       10, 32'h00000005, 32'h19999999};
    v[11] = '{3'd2, 32'd7,        32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD};
    v[12] = '{3'd6, 32'hAAAAAAAA, 32'd1,        0,  32'h0,        32'h0};
    v[13] = '{3'd7, 32'h55555555, 32'd1,        0,  32'h0,        32'h0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // mthi / mtlo on consecutive cycles
    start = 1'b1; md_op = 3'd4; a = 32'h12345678;
    @(negedge clk);
    chk("mthi_hi", hi, 32'h12345678);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    md_op = 3'd5; a = 32'h9ABCDEF0;
    @(negedge clk);
    start = 1'b0;
    chk("mtlo_lo", lo, 32'h9ABCDEF0);
    chk("mtlo_hi", hi, 32'h12345678);
    chk("mtlo_busy", {31'd0, busy}, 32'd0);

    // Vector table
    ph = hi; pl = lo;
    for (int i = 0; i < 14; i++) begin
      eh = v[i].hi; el = v[i].lo; ec = v[i].cyc;
      if (v[i].op >= 3'd6 || (v[i].op inside {3'd2, 3'd3} && !DIV_EN)) begin
        eh = ph; el = pl; ec = 0;
      end
      @(negedge clk);
      chk($sformatf("v%0d_idle_busy", i), {31'd0, busy}, 32'd0);
      start = 1'b1; md_op = v[i].op; a = v[i].a; b = v[i].b;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (busy && n < 40) begin
        chk($sformatf("v%0d_hold_hi", i), hi, ph);
        chk($sformatf("v%0d_hold_lo", i), lo, pl);
        n++;
        @(negedge clk);
      end
      chk($sformatf("v%0d_cycles", i), 32'(n), 32'(ec));
      chk($sformatf("v%0d_hi", i), hi, eh);
      chk($sformatf("v%0d_lo", i), lo, el);
      ph = eh; pl = el;
    end

    // mtlo while busy is ignored; back-to-back mult at completion
    @(negedge clk);
    start = 1'b1; md_op = 3'd0; a = 32'd3; b = 32'd4;       // cycle T
    @(negedge clk);
    start = 1'b0;
    chk("bb_busy_t1", {31'd0, busy}, 32'd1);
    @(negedge clk);
    start = 1'b1; md_op = 3'd5; a = 32'hDEADBEEF;           // T+2, ignored
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);                                          // T+5
    chk("bb_busy_t5", {31'd0, busy}, 32'd1);
    chk("bb_lo_t5", lo, pl);
    @(negedge clk);                                          // T+6
    chk("bb_busy_t6", {31'd0, busy}, 32'd0);
    chk("bb_hi_t6", hi, 32'd0);
    chk("bb_lo_t6", lo, 32'd12);
    start = 1'b1; md_op = 3'd0; a = 32'd2; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("bb2_cycles", 32'(n), 32'd5);
    chk("bb2_hi", hi, 32'd0);
    chk("bb2_lo", lo, 32'd10);

    // Reset mid-divide aborts with no later write
    start = 1'b1; md_op = 3'd4; a = 32'h0BADF00D;
    @(negedge clk);
    start = 1'b1; md_op = 3'd2; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rmid_busy", {31'd0, busy}, 32'd0);
    chk("rmid_hi", hi, 32'd0);
    chk("rmid_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    repeat (12) begin
      @(negedge clk);
      if (busy || hi != 32'd0 || lo != 32'd0) n++;
    end
    chk("rmid_after", 32'(n), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
